// File: rtl/cac_fpf_enc5_seq_pkg.sv
// ---------------------------------------------------------------------------
// cac_fpf_enc5_seq_pkg
// Shared widths and types for the 5-wire FPF-CAC bit-serial encoder.
// These widths stand in for the shared Fibo.vh macros, including FNSLEN_06.
//   BLEN_05   : width of the binary word and of the working residual
//   FNSLEN_0n : width of the n-th Fibonacci numeral system term
// ---------------------------------------------------------------------------
package cac_fpf_enc5_seq_pkg;

  localparam int BLEN_05   = 4;
  localparam int FNSLEN_03 = 2;
  localparam int FNSLEN_04 = 2;
  localparam int FNSLEN_05 = 3;
  localparam int FNSLEN_06 = 4;
  localparam int CODE_W    = 5;

  // Residual and weights share one width so that every compare is unsigned
  // and like-sized once the weights are zero-extended.
  typedef logic [BLEN_05-1:0] resid_t;
  typedef logic [2:0]         bitIdx_t;
  typedef logic [CODE_W-1:0]  code_t;

  localparam bitIdx_t K_TOP    = 3'd4;
  localparam resid_t  RESID_ONE = resid_t'(1);

endpackage

// File: rtl/cac_fpf_enc5_seq_if.sv
// ---------------------------------------------------------------------------
// cac_fpf_enc5_seq_if
// Input and output handshakes of the FPF-CAC encoder.
//   in_valid/in_ready   : word handshake, datain and FNS03..FNS06 qualify it
//   out_valid/out_ready : codeword handshake, codeout and range_err qualify it
// Modport slave is the encoder side, master is the producer/consumer side.
// ---------------------------------------------------------------------------
interface cac_fpf_enc5_seq_if;
  import cac_fpf_enc5_seq_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [BLEN_05-1:0]   datain;
  logic [FNSLEN_03-1:0] FNS03;
  logic [FNSLEN_04-1:0] FNS04;
  logic [FNSLEN_05-1:0] FNS05;
  logic [FNSLEN_06-1:0] FNS06;
  logic                 out_valid;
  logic                 out_ready;
  logic [CODE_W-1:0]    codeout;
  logic                 range_err;

  modport slave (
    input  in_valid, datain, FNS03, FNS04, FNS05, FNS06, out_ready,
    output in_ready, out_valid, codeout, range_err
  );

  modport master (
    output in_valid, datain, FNS03, FNS04, FNS05, FNS06, out_ready,
    input  in_ready, out_valid, codeout, range_err
  );

endinterface

// File: rtl/cac_fpf_enc5_seq_bitstep.sv
// ---------------------------------------------------------------------------
// cac_fpf_bitstep
// One combinational FPF decision for a single codeword bit.
//   i_r      : current residual
//   i_lo     : weight of this bit
//   i_hi     : weight of the next-higher bit (upper threshold)
//   i_prev   : already-resolved code bit just above this one
//   o_bit    : resolved code bit
//   o_nextR  : residual after removing this bit's weight
// ---------------------------------------------------------------------------
module cac_fpf_bitstep
  import cac_fpf_enc5_seq_pkg::*;
(
  input  resid_t i_r,
  input  resid_t i_lo,
  input  resid_t i_hi,
  input  logic   i_prev,
  output logic   o_bit,
  output resid_t o_nextR
);

  // Between the thresholds either choice is representable, so copying the
  // bit above keeps runs together and avoids the 010/101 patterns.
  always_comb begin
    o_bit = i_prev;
    if (i_r >= i_hi) begin
      o_bit = 1'b1;
    end else if (i_r < i_lo) begin
      o_bit = 1'b0;
    end
  end

  // Subtraction only happens when r >= lo, so the residual cannot wrap.
  assign o_nextR = o_bit ? (i_r - i_lo) : i_r;

endmodule

// File: rtl/cac_fpf_enc5_seq.sv
// ---------------------------------------------------------------------------
// cac_fpf_enc5_seq
// Bit-serial encoder from a binary word to a 5-wire FPF crosstalk avoidance
// codeword in the Fibonacci numeral system, one bit per cycle MSB first.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   enc : handshake bundle (slave side), see cac_fpf_enc5_seq_if
// Code bit k carries weight w_{k+1}: 1, 1, FNS03, FNS04, FNS05.
// ---------------------------------------------------------------------------
module cac_fpf_enc5_seq
  import cac_fpf_enc5_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  cac_fpf_enc5_seq_if.slave   enc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t  r_state;
  resid_t  r_resid;
  bitIdx_t r_k;
  code_t   r_code;
  logic    r_outValid;
  logic    r_rangeErr;
  resid_t  r_w3;
  resid_t  r_w4;
  resid_t  r_w5;
  resid_t  r_w6;

  resid_t  w_lo;
  resid_t  w_hi;
  logic    w_prev;
  logic    w_bit;
  resid_t  w_nextResid;

  // Select this bit's weight, the threshold above it and the bit already
  // resolved above it. The MSB has no neighbour above, so prev is 0 there;
  // bits 1 and 0 use the fixed unit weights w1 = w2 = 1.
  always_comb begin
    w_lo   = RESID_ONE;
    w_hi   = RESID_ONE;
    w_prev = 1'b0;
    case (r_k)
      3'd4: begin
        w_lo   = r_w5;
        w_hi   = r_w6;
        w_prev = 1'b0;
      end
      3'd3: begin
        w_lo   = r_w4;
        w_hi   = r_w5;
        w_prev = r_code[4];
      end
      3'd2: begin
        w_lo   = r_w3;
        w_hi   = r_w4;
        w_prev = r_code[3];
      end
      3'd1: begin
        w_lo   = RESID_ONE;
        w_hi   = r_w3;
        w_prev = r_code[2];
      end
      default: begin
        w_lo   = RESID_ONE;
        w_hi   = RESID_ONE;
        w_prev = r_code[1];
      end
    endcase
  end

  cac_fpf_bitstep u_bitstep (
    .i_r     (r_resid),
    .i_lo    (w_lo),
    .i_hi    (w_hi),
    .i_prev  (w_prev),
    .o_bit   (w_bit),
    .o_nextR (w_nextResid)
  );

  // Control FSM and datapath registers. Weights are captured with the word
  // so upstream may change them while the word is being encoded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_resid    <= '0;
      r_k        <= K_TOP;
      r_code     <= '0;
      r_outValid <= 1'b0;
      r_rangeErr <= 1'b0;
      r_w3       <= '0;
      r_w4       <= '0;
      r_w5       <= '0;
      r_w6       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enc.in_valid) begin
            r_resid    <= enc.datain;
            r_k        <= K_TOP;
            r_code     <= '0;
            r_rangeErr <= 1'b0;
            r_w3       <= resid_t'(enc.FNS03);
            r_w4       <= resid_t'(enc.FNS04);
            r_w5       <= resid_t'(enc.FNS05);
            r_w6       <= resid_t'(enc.FNS06);
            r_state    <= ENC;
          end
        end
        ENC: begin
          r_code[r_k] <= w_bit;
          r_resid     <= w_nextResid;
          if (r_k == 3'd0) begin
            // A leftover residual means the word was beyond the code range.
            r_rangeErr <= (w_nextResid != '0);
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_k <= r_k - 3'd1;
          end
        end
        DONE: begin
          if (enc.out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Ready is gated by reset so no word is accepted while reset is held.
  assign enc.in_ready  = (r_state == IDLE) && !rst;
  assign enc.out_valid = r_outValid;
  assign enc.codeout   = r_code;
  assign enc.range_err = r_rangeErr;

endmodule

// File: tb/tb_cac_fpf_enc5_seq.sv
// ---------------------------------------------------------------------------
// tb_cac_fpf_enc5_seq
// Directed self-checking bench for the FPF-CAC bit-serial encoder.
// ---------------------------------------------------------------------------
module tb_cac_fpf_enc5_seq;
  import cac_fpf_enc5_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cac_fpf_enc5_seq_if encIf ();

  cac_fpf_enc5_seq dut (
    .clk (clk),
    .rst (rst),
    .enc (encIf)
  );

  // Hand-computed codewords for datain 0..13 with weights 1,1,2,3,5.
  logic [4:0] expCode [0:13];
  initial begin
    expCode[0]  = 5'b00000; expCode[1]  = 5'b00001; expCode[2]  = 5'b00011;
    expCode[3]  = 5'b00110; expCode[4]  = 5'b00111; expCode[5]  = 5'b01100;
    expCode[6]  = 5'b01110; expCode[7]  = 5'b01111; expCode[8]  = 5'b11000;
    expCode[9]  = 5'b11001; expCode[10] = 5'b11100; expCode[11] = 5'b11110;
    expCode[12] = 5'b11111; expCode[13] = 5'b11111;
  end

  // Safety net so the run cannot hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int decodeSum(input logic [4:0] c);
    return int'(c[0]) + int'(c[1]) + 2 * int'(c[2]) + 3 * int'(c[3]) + 5 * int'(c[4]);
  endfunction

  function automatic logic isFpf(input logic [4:0] c);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (c[i+2 -: 3] == 3'b010 || c[i+2 -: 3] == 3'b101) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic setStdWeights();
    encIf.FNS03 = 2'd2;
    encIf.FNS04 = 2'd3;
    encIf.FNS05 = 3'd5;
    encIf.FNS06 = 4'd8;
  endtask

  // Wait (bounded) for ready, present one word, and count edges from the
  // accept edge until out_valid is seen. Leaves the word waiting in DONE.
  task automatic applyStimulus(input logic [3:0] data, output int latency);
    int waitCnt;
    waitCnt = 0;
    while (!encIf.in_ready && waitCnt < 20) begin
      @(posedge clk); @(negedge clk);
      waitCnt++;
    end
    checkOutput("inReadyBeforeWord", 32'(encIf.in_ready), 32'd1);
    encIf.datain   = data;
    encIf.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    encIf.in_valid = 1'b0;
    latency = 0;
    while (!encIf.out_valid && latency < 20) begin
      @(posedge clk); @(negedge clk);
      latency++;
    end
  endtask

  task automatic releaseWord();
    encIf.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    encIf.out_ready = 1'b0;
  endtask

  initial begin
    int         lat;
    int         inIdx;
    int         outIdx;
    int         cyc;
    int         lastOut;
    logic       acc;
    logic [3:0] streamWords [0:2];
    logic [4:0] streamCodes [0:2];

    rst             = 1'b1;
    encIf.in_valid  = 1'b0;
    encIf.out_ready = 1'b0;
    encIf.datain    = '0;
    setStdWeights();

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rstInReady", 32'(encIf.in_ready), 32'd0);
    checkOutput("rstOutValid", 32'(encIf.out_valid), 32'd0);
    checkOutput("rstCode", 32'(encIf.codeout), 32'd0);
    checkOutput("rstRangeErr", 32'(encIf.range_err), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("idleInReady", 32'(encIf.in_ready), 32'd1);
    @(negedge clk);

    // Directed words exercising the prev-copy rule.
    applyStimulus(4'd4, lat);
    checkOutput("lat4", 32'(lat), 32'd5);
    checkOutput("code4", 32'(encIf.codeout), 32'(5'b00111));
    checkOutput("err4", 32'(encIf.range_err), 32'd0);
    releaseWord();
    applyStimulus(4'd3, lat);
    checkOutput("code3", 32'(encIf.codeout), 32'(5'b00110));
    releaseWord();
    applyStimulus(4'd5, lat);
    checkOutput("code5", 32'(encIf.codeout), 32'(5'b01100));
    releaseWord();
    applyStimulus(4'd8, lat);
    checkOutput("code8", 32'(encIf.codeout), 32'(5'b11000));
    releaseWord();
    applyStimulus(4'd12, lat);
    checkOutput("code12", 32'(encIf.codeout), 32'(5'b11111));
    releaseWord();

    // Full sweep of the representable range plus the first overflow value.
    for (int d = 0; d <= 13; d++) begin
      applyStimulus(4'(d), lat);
      checkOutput($sformatf("sweepLat%0d", d), 32'(lat), 32'd5);
      checkOutput($sformatf("sweepCode%0d", d), 32'(encIf.codeout), 32'(expCode[d]));
      checkOutput($sformatf("sweepFpf%0d", d), 32'(isFpf(encIf.codeout)), 32'd1);
      if (d <= 12) begin
        checkOutput($sformatf("sweepSum%0d", d), 32'(decodeSum(encIf.codeout)), 32'(d));
        checkOutput($sformatf("sweepErr%0d", d), 32'(encIf.range_err), 32'd0);
      end else begin
        checkOutput("overflowErr", 32'(encIf.range_err), 32'd1);
      end
      releaseWord();
    end

    // Inputs scrambled during ENC and out_ready held low in DONE.
    checkOutput("holdInReady0", 32'(encIf.in_ready), 32'd1);
    encIf.datain   = 4'd5;
    encIf.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    encIf.in_valid = 1'b0;
    encIf.datain   = 4'd15;
    encIf.FNS03    = 2'd3;
    encIf.FNS04    = 2'd1;
    encIf.FNS05    = 3'd7;
    encIf.FNS06    = 4'd2;
    lat = 0;
    while (!encIf.out_valid && lat < 20) begin
      checkOutput("holdEncInReady", 32'(encIf.in_ready), 32'd0);
      @(posedge clk); @(negedge clk);
      lat++;
    end
    checkOutput("holdLat", 32'(lat), 32'd5);
    for (int i = 0; i < 10; i++) begin
      checkOutput("holdCode", 32'(encIf.codeout), 32'(5'b01100));
      checkOutput("holdErr", 32'(encIf.range_err), 32'd0);
      checkOutput("holdValid", 32'(encIf.out_valid), 32'd1);
      checkOutput("holdInReady", 32'(encIf.in_ready), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    releaseWord();
    checkOutput("holdReleaseInReady", 32'(encIf.in_ready), 32'd1);
    checkOutput("holdReleaseValid", 32'(encIf.out_valid), 32'd0);
    setStdWeights();

    // Reset in the middle of a word, when bit index 2 is next.
    encIf.datain   = 4'd12;
    encIf.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    encIf.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checkOutput("midRstInReady", 32'(encIf.in_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("midRstValid", 32'(encIf.out_valid), 32'd0);
    checkOutput("midRstCode", 32'(encIf.codeout), 32'd0);
    checkOutput("midRstErr", 32'(encIf.range_err), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("midRstIdle", 32'(encIf.in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(4'd7, lat);
    checkOutput("postRstLat", 32'(lat), 32'd5);
    checkOutput("postRstCode", 32'(encIf.codeout), 32'(5'b01111));
    releaseWord();

    // Back-to-back stream with both handshakes held open.
    streamWords[0] = 4'd1;  streamCodes[0] = 5'b00001;
    streamWords[1] = 4'd6;  streamCodes[1] = 5'b01110;
    streamWords[2] = 4'd9;  streamCodes[2] = 5'b11001;
    inIdx   = 0;
    outIdx  = 0;
    lastOut = 0;
    encIf.out_ready = 1'b1;
    for (cyc = 0; cyc < 60 && outIdx < 3; cyc++) begin
      if (inIdx < 3) begin
        encIf.datain   = streamWords[inIdx];
        encIf.in_valid = 1'b1;
      end else begin
        encIf.in_valid = 1'b0;
      end
      #1;
      acc = encIf.in_ready && encIf.in_valid;
      if (encIf.out_valid) begin
        checkOutput($sformatf("streamCode%0d", outIdx), 32'(encIf.codeout),
                    32'(streamCodes[outIdx]));
        if (outIdx > 0) begin
          checkOutput($sformatf("streamPeriod%0d", outIdx), 32'(cyc - lastOut), 32'd7);
        end
        lastOut = cyc;
        outIdx++;
      end
      @(posedge clk); @(negedge clk);
      if (acc) inIdx++;
    end
    encIf.in_valid = 1'b0;
    checkOutput("streamOutCount", 32'(outIdx), 32'd3);
    checkOutput("streamInCount", 32'(inIdx), 32'd3);
    for (int i = 0; i < 8; i++) begin
      checkOutput("streamNoDup", 32'(encIf.out_valid), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    encIf.out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
